// File: rtl/dwc_upconv_wchan_pack_ctrl_pkg.sv
// Shared definitions for the W-channel up-converter pack controller:
// FSM state encoding, offset/counter widths and the lane-mask helper.
package dwc_upconv_wchan_pack_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ACCEPT = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4
  } pack_state_e;

  localparam int OFFS_W     = 6;
  localparam int CNT_W      = 8;
  localparam int DEF_OBYTES = 8;

  // Byte offsets wrap inside one wide word, so the mask is OBYTES-1.
  function automatic logic [OFFS_W-1:0] lane_mask(input int obytes);
    return OFFS_W'(obytes - 1);
  endfunction

endpackage

// File: rtl/dwc_upconv_wchan_pack_ctrl_if.sv
// Command, slave-W, master-W and pack-control bundle of the pack controller.
// The slave modport is the controller view; master is the surrounding datapath.
interface dwc_upconv_wchan_pack_ctrl_if;
  import dwc_upconv_wchan_pack_ctrl_pkg::*;

  logic              hold_reg_empty;
  logic              hold_get_next_data;
  logic [OFFS_W-1:0] addr;
  logic [OFFS_W-1:0] size_shifted;
  logic [OFFS_W-1:0] mask_addr;
  logic [CNT_W-1:0]  wlen_mst;
  logic              fixed_flag;
  logic              extend_tx;
  logic              s_wvalid;
  logic              s_wlast;
  logic              s_wready;
  logic              pack_en;
  logic [OFFS_W-1:0] pack_lane;
  logic              pack_clr;
  logic              m_wvalid;
  logic              m_wlast;
  logic              m_wready;
  logic              err_early_last;

  modport master (
    output hold_reg_empty, addr, size_shifted, mask_addr, wlen_mst,
           fixed_flag, extend_tx, s_wvalid, s_wlast, m_wready,
    input  hold_get_next_data, s_wready, pack_en, pack_lane, pack_clr,
           m_wvalid, m_wlast, err_early_last
  );

  modport slave (
    input  hold_reg_empty, addr, size_shifted, mask_addr, wlen_mst,
           fixed_flag, extend_tx, s_wvalid, s_wlast, m_wready,
    output hold_get_next_data, s_wready, pack_en, pack_lane, pack_clr,
           m_wvalid, m_wlast, err_early_last
  );

endinterface

// File: rtl/dwc_upconv_wchan_pack_ctrl_lane_tracker.sv
// Byte-lane tracker: holds the current lane offset inside the wide word and
// computes the following lane plus the word-wrap carry.
module upconv_lane_tracker
  import dwc_upconv_wchan_pack_ctrl_pkg::*;
#(
  parameter int OBYTES = DEF_OBYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [OFFS_W-1:0] addr,
  input  logic [OFFS_W-1:0] mask_addr,
  input  logic [OFFS_W-1:0] size_shifted,
  input  logic              fixed_flag,
  output logic [OFFS_W-1:0] offset,
  output logic              carry
);

  localparam logic [OFFS_W-1:0] LANE_MASK = lane_mask(OBYTES);

  logic [OFFS_W-1:0] offset_r;
  logic [OFFS_W-1:0] next_s;
  logic              carry_s;

  // Next lane: FIXED bursts reuse the lane, otherwise step by beat size and wrap.
  always_comb begin
    if (fixed_flag) begin
      next_s  = offset_r;
      carry_s = 1'b0;
    end else begin
      next_s  = (offset_r + size_shifted) & LANE_MASK;
      carry_s = (next_s == {OFFS_W{1'b0}});
    end
  end

  // Offset register: loaded from the entry start address, then stepped per beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      offset_r <= {OFFS_W{1'b0}};
    end else if (load) begin
      offset_r <= addr & mask_addr & LANE_MASK;
    end else if (advance) begin
      offset_r <= next_s;
    end
  end

  assign offset = offset_r;
  assign carry  = carry_s;

endmodule

// File: rtl/dwc_upconv_wchan_pack_ctrl.sv
// Write-data up-converter sequencing: packs narrow slave W beats into wide
// master beats and retires the hold-register entry after its last master beat.
module dwc_upconv_wchan_pack_ctrl
  import dwc_upconv_wchan_pack_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH_IN  = 32,
  parameter int DATA_WIDTH_OUT = 64
) (
  input logic                          clk,
  input logic                          rst,
  dwc_upconv_wchan_pack_ctrl_if.slave  bus
);

  localparam int OBYTES = DATA_WIDTH_OUT / 32'd8;

  if ((DATA_WIDTH_OUT < DATA_WIDTH_IN) || (DATA_WIDTH_OUT > 32'd512) ||
      ((DATA_WIDTH_OUT & (DATA_WIDTH_OUT - 32'd1)) != 32'd0)) begin : g_cfg_check
    $error("dwc_upconv_wchan_pack_ctrl: unsupported data width configuration");
  end

  pack_state_e       state_r;
  logic [CNT_W-1:0]  mst_cnt_r;
  logic              s_wready_r;
  logic              m_wvalid_r;
  logic              m_wlast_r;
  logic              pack_clr_r;
  logic              hold_get_r;

  logic [OFFS_W-1:0] offset_s;
  logic              carry_s;
  logic              eff_last_s;
  logic              last_s;
  logic              s_hs_s;
  logic              m_hs_s;
  logic              word_done_s;
  logic              early_s;
  logic              load_s;
  logic              advance_s;
  logic [OFFS_W-1:0] lane_s;

  upconv_lane_tracker #(
    .OBYTES (OBYTES)
  ) u_lane_tracker (
    .clk          (clk),
    .rst          (rst),
    .load         (load_s),
    .advance      (advance_s),
    .addr         (bus.addr),
    .mask_addr    (bus.mask_addr),
    .size_shifted (bus.size_shifted),
    .fixed_flag   (bus.fixed_flag),
    .offset       (offset_s),
    .carry        (carry_s)
  );

  // Handshake decode; an extended entry ignores s_wlast and ends on the beat count.
  always_comb begin
    eff_last_s = bus.s_wlast & ~bus.extend_tx;
    last_s     = (mst_cnt_r == bus.wlen_mst) | eff_last_s;
    m_hs_s     = m_wvalid_r & bus.m_wready;
    load_s     = (state_r == ST_LOAD);
    if ((state_r == ST_ACCEPT) && bus.s_wvalid) begin
      s_hs_s      = 1'b1;
      lane_s      = offset_s;
      word_done_s = bus.fixed_flag | carry_s | eff_last_s;
      early_s     = eff_last_s & (mst_cnt_r < bus.wlen_mst);
    end else begin
      s_hs_s      = 1'b0;
      lane_s      = {OFFS_W{1'b0}};
      word_done_s = 1'b0;
      early_s     = 1'b0;
    end
    advance_s = (s_hs_s & ~word_done_s) | (m_hs_s & ~m_wlast_r);
  end

  // Sequencing FSM with registered Moore outputs; m_wlast_r doubles as last_beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      mst_cnt_r  <= {CNT_W{1'b0}};
      s_wready_r <= 1'b0;
      m_wvalid_r <= 1'b0;
      m_wlast_r  <= 1'b0;
      pack_clr_r <= 1'b0;
      hold_get_r <= 1'b0;
    end else begin
      pack_clr_r <= 1'b0;
      hold_get_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!bus.hold_reg_empty) begin
            state_r    <= ST_LOAD;
            pack_clr_r <= 1'b1;
          end
        end
        ST_LOAD: begin
          mst_cnt_r  <= {CNT_W{1'b0}};
          s_wready_r <= 1'b1;
          state_r    <= ST_ACCEPT;
        end
        ST_ACCEPT: begin
          if (s_hs_s && word_done_s) begin
            s_wready_r <= 1'b0;
            m_wvalid_r <= 1'b1;
            m_wlast_r  <= last_s;
            state_r    <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (m_hs_s) begin
            m_wvalid_r <= 1'b0;
            m_wlast_r  <= 1'b0;
            pack_clr_r <= 1'b1;
            if (m_wlast_r) begin
              hold_get_r <= 1'b1;
              state_r    <= ST_DONE;
            end else begin
              mst_cnt_r  <= mst_cnt_r + 8'd1;
              s_wready_r <= 1'b1;
              state_r    <= ST_ACCEPT;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          s_wready_r <= 1'b0;
          m_wvalid_r <= 1'b0;
          m_wlast_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hold_get_next_data = hold_get_r;
  assign bus.s_wready           = s_wready_r;
  assign bus.pack_en            = s_hs_s;
  assign bus.pack_lane          = lane_s;
  assign bus.pack_clr           = pack_clr_r;
  assign bus.m_wvalid           = m_wvalid_r;
  assign bus.m_wlast            = m_wlast_r;
  assign bus.err_early_last     = early_s;

endmodule

// File: tb/tb_dwc_upconv_wchan_pack_ctrl.sv
// Directed bench for the W-channel pack controller (IN=32, OUT=64).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_dwc_upconv_wchan_pack_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dwc_upconv_wchan_pack_ctrl_if bus ();

  dwc_upconv_wchan_pack_ctrl #(
    .DATA_WIDTH_IN  (32),
    .DATA_WIDTH_OUT (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] lane_hist;
  logic [7:0]  mlast_hist;
  logic [31:0] sb_hist;
  int n_lanes, n_m, hold_cnt, err_cnt, err_beat, clr_cnt;
  int cyc_sready, cyc_mvalid, cyc_hold_gap, stall_seen, stall_viol;

  // Runs one hold entry and records what the controller did; starts and ends on a falling edge.
  task automatic run_entry(input logic [5:0] a, input logic [5:0] sz, input logic [7:0] wl,
                           input logic fx, input logic ext, input int nbeats,
                           input int wlast_idx, input int stall, input bit keep_full);
    int  beat = 0;
    int  cyc = 0;
    int  stall_left = stall;
    int  last_m_cyc = -1;
    bit  done = 0;
    bit  in_stall;
    logic wlast_ref = 1'b0;
    lane_hist = '0; mlast_hist = '0; sb_hist = '0;
    n_lanes = 0; n_m = 0; hold_cnt = 0; err_cnt = 0; err_beat = -1; clr_cnt = 0;
    cyc_sready = -1; cyc_mvalid = -1; cyc_hold_gap = -1; stall_seen = 0; stall_viol = 0;
    bus.addr = a; bus.size_shifted = sz; bus.mask_addr = 6'h07; bus.wlen_mst = wl;
    bus.fixed_flag = fx; bus.extend_tx = ext; bus.hold_reg_empty = 1'b0;
    while (!done && cyc < 200) begin
      in_stall = 0;
      bus.s_wvalid = (beat < nbeats);
      bus.s_wlast  = (beat == wlast_idx);
      if (bus.m_wvalid && stall_left > 0) begin
        bus.m_wready = 1'b0; stall_left--; in_stall = 1;
      end else begin
        bus.m_wready = bus.m_wvalid;
      end
      if (bus.hold_get_next_data && !keep_full) bus.hold_reg_empty = 1'b1;
      #1;
      if (bus.s_wready && cyc_sready < 0) cyc_sready = cyc;
      if (bus.m_wvalid && cyc_mvalid < 0) cyc_mvalid = cyc;
      if (bus.pack_clr) clr_cnt++;
      if (bus.err_early_last) begin err_cnt++; err_beat = beat; end
      if (in_stall) begin
        if (stall_seen == 0) wlast_ref = bus.m_wlast;
        stall_seen++;
        if (!bus.m_wvalid || bus.m_wlast !== wlast_ref || bus.s_wready || bus.pack_en) stall_viol++;
      end
      if (bus.m_wvalid && bus.m_wready) begin
        mlast_hist = {mlast_hist[6:0], bus.m_wlast};
        sb_hist = {sb_hist[23:0], 8'(beat)};
        n_m++; last_m_cyc = cyc;
      end
      if (bus.pack_en) begin
        lane_hist = {lane_hist[55:0], 2'b00, bus.pack_lane};
        n_lanes++; beat++;
      end
      if (bus.hold_get_next_data) begin
        hold_cnt++; cyc_hold_gap = cyc - last_m_cyc; done = 1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.s_wvalid = 1'b0; bus.s_wlast = 1'b0; bus.m_wready = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL entry_timeout got no hold_get_next_data within 200 cycles exp pulse");
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({bus.hold_get_next_data, bus.s_wready, bus.pack_en, bus.pack_lane, bus.pack_clr,
         bus.m_wvalid, bus.m_wlast, bus.err_early_last} !== 13'h0) begin
      errors++; $display("FAIL reset_outputs got nonzero outputs exp all 0");
    end
    @(negedge clk); rst = 1'b1; bus.s_wvalid = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({bus.s_wready, bus.pack_en, bus.pack_clr, bus.m_wvalid} !== 4'h0) begin
      errors++; $display("FAIL idle_empty got %b exp 0000", {bus.s_wready, bus.pack_en, bus.pack_clr, bus.m_wvalid});
    end
    @(negedge clk); bus.s_wvalid = 1'b0;
  endtask

  task automatic test_incr;
    run_entry(6'h00, 6'd4, 8'd1, 1'b0, 1'b0, 4, 3, 0, 1'b0);
    checks++; if (lane_hist !== 64'h0000_0000_0004_0004 || n_lanes != 4) begin errors++; $display("FAIL incr_lanes got %h/%0d exp 0000000000040004/4", lane_hist, n_lanes); end
    checks++; if (mlast_hist !== 8'b01 || n_m != 2) begin errors++; $display("FAIL incr_mlast got %b/%0d exp 01/2", mlast_hist, n_m); end
    checks++; if (sb_hist !== 32'h0204) begin errors++; $display("FAIL incr_beats_per_m got %h exp 0204", sb_hist); end
    checks++; if (hold_cnt != 1 || err_cnt != 0) begin errors++; $display("FAIL incr_hold_err got %0d/%0d exp 1/0", hold_cnt, err_cnt); end
    checks++; if (clr_cnt != 3) begin errors++; $display("FAIL incr_pack_clr got %0d exp 3", clr_cnt); end
    checks++; if (cyc_sready != 2) begin errors++; $display("FAIL incr_sready_latency got %0d exp 2", cyc_sready); end
    checks++; if (cyc_mvalid != 4) begin errors++; $display("FAIL incr_mvalid_latency got %0d exp 4", cyc_mvalid); end
    checks++; if (cyc_hold_gap != 1) begin errors++; $display("FAIL incr_hold_latency got %0d exp 1", cyc_hold_gap); end
    // hold register went empty during DONE: no new entry, stray slave beat must wait
    for (int i = 0; i < 3; i++) begin
      bus.s_wvalid = 1'b1; #1;
      checks++;
      if ({bus.s_wready, bus.pack_en, bus.pack_clr, bus.m_wvalid, bus.hold_get_next_data} !== 5'h0) begin
        errors++; $display("FAIL incr_stay_idle got %b exp 00000", {bus.s_wready, bus.pack_en, bus.pack_clr, bus.m_wvalid, bus.hold_get_next_data});
      end
      @(negedge clk);
    end
    bus.s_wvalid = 1'b0;
  endtask

  task automatic test_unaligned;
    run_entry(6'h04, 6'd4, 8'd1, 1'b0, 1'b0, 3, 2, 0, 1'b0);
    checks++; if (lane_hist !== 64'h04_0004 || n_lanes != 3) begin errors++; $display("FAIL unal_lanes got %h/%0d exp 040004/3", lane_hist, n_lanes); end
    checks++; if (mlast_hist !== 8'b01 || n_m != 2) begin errors++; $display("FAIL unal_mlast got %b/%0d exp 01/2", mlast_hist, n_m); end
    checks++; if (sb_hist !== 32'h0103) begin errors++; $display("FAIL unal_beats_per_m got %h exp 0103", sb_hist); end
    checks++; if (cyc_mvalid != 3) begin errors++; $display("FAIL unal_mvalid_latency got %0d exp 3", cyc_mvalid); end
  endtask

  task automatic test_fixed;
    run_entry(6'h04, 6'd4, 8'd2, 1'b1, 1'b0, 3, 2, 0, 1'b0);
    checks++; if (lane_hist !== 64'h04_0404 || n_lanes != 3) begin errors++; $display("FAIL fixed_lanes got %h/%0d exp 040404/3", lane_hist, n_lanes); end
    checks++; if (mlast_hist !== 8'b001 || n_m != 3) begin errors++; $display("FAIL fixed_mlast got %b/%0d exp 001/3", mlast_hist, n_m); end
    checks++; if (sb_hist !== 32'h01_0203) begin errors++; $display("FAIL fixed_beats_per_m got %h exp 010203", sb_hist); end
    checks++; if (hold_cnt != 1) begin errors++; $display("FAIL fixed_hold got %0d exp 1", hold_cnt); end
  endtask

  task automatic test_byte;
    run_entry(6'h00, 6'd1, 8'd0, 1'b0, 1'b0, 8, -1, 0, 1'b0);
    checks++; if (lane_hist !== 64'h0001_0203_0405_0607 || n_lanes != 8) begin errors++; $display("FAIL byte_lanes got %h/%0d exp 0001020304050607/8", lane_hist, n_lanes); end
    checks++; if (mlast_hist !== 8'b1 || n_m != 1 || sb_hist !== 32'h08) begin errors++; $display("FAIL byte_mbeat got %b/%0d/%h exp 1/1/08", mlast_hist, n_m, sb_hist); end
  endtask

  task automatic test_backpressure;
    run_entry(6'h00, 6'd4, 8'd1, 1'b0, 1'b0, 4, 3, 5, 1'b0);
    checks++; if (stall_seen != 5) begin errors++; $display("FAIL bp_stall_cycles got %0d exp 5", stall_seen); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable got %0d bad cycles exp 0", stall_viol); end
    checks++; if (lane_hist !== 64'h0004_0004 || mlast_hist !== 8'b01 || n_m != 2) begin errors++; $display("FAIL bp_resume got %h/%b/%0d exp 00040004/01/2", lane_hist, mlast_hist, n_m); end
    checks++; if (hold_cnt != 1 || cyc_hold_gap != 1) begin errors++; $display("FAIL bp_hold got %0d/%0d exp 1/1", hold_cnt, cyc_hold_gap); end
  endtask

  task automatic test_early_last;
    run_entry(6'h00, 6'd4, 8'd3, 1'b0, 1'b0, 2, 1, 0, 1'b0);
    checks++; if (err_cnt != 1 || err_beat != 1) begin errors++; $display("FAIL early_err got %0d pulses at beat %0d exp 1 at 1", err_cnt, err_beat); end
    checks++; if (mlast_hist !== 8'b1 || n_m != 1) begin errors++; $display("FAIL early_mlast got %b/%0d exp 1/1", mlast_hist, n_m); end
    checks++; if (lane_hist !== 64'h0004 || hold_cnt != 1) begin errors++; $display("FAIL early_lanes_hold got %h/%0d exp 0004/1", lane_hist, hold_cnt); end
  endtask

  task automatic test_back_to_back;
    run_entry(6'h00, 6'd4, 8'd0, 1'b0, 1'b1, 2, -1, 0, 1'b1);
    checks++; if (lane_hist !== 64'h0004 || mlast_hist !== 8'b1 || n_m != 1) begin errors++; $display("FAIL b2b_first got %h/%b/%0d exp 0004/1/1", lane_hist, mlast_hist, n_m); end
    run_entry(6'h04, 6'd4, 8'd0, 1'b0, 1'b0, 1, 0, 0, 1'b0);
    checks++; if (cyc_sready != 2) begin errors++; $display("FAIL b2b_accept_latency got %0d exp 2", cyc_sready); end
    checks++; if (lane_hist !== 64'h04 || mlast_hist !== 8'b1 || hold_cnt != 1) begin errors++; $display("FAIL b2b_second got %h/%b/%0d exp 04/1/1", lane_hist, mlast_hist, hold_cnt); end
  endtask

  task automatic test_reset_mid;
    int guard = 0;
    bus.addr = 6'h00; bus.size_shifted = 6'd4; bus.mask_addr = 6'h07; bus.wlen_mst = 8'd1;
    bus.fixed_flag = 1'b0; bus.extend_tx = 1'b0; bus.s_wlast = 1'b0; bus.m_wready = 1'b0;
    bus.hold_reg_empty = 1'b0; bus.s_wvalid = 1'b1;
    while (!bus.s_wready && guard < 10) begin @(negedge clk); guard++; end
    @(negedge clk); #1;
    checks++;
    if (bus.pack_en !== 1'b1 || bus.pack_lane !== 6'd4) begin
      errors++; $display("FAIL rstmid_second_beat got en=%b lane=%0d exp en=1 lane=4", bus.pack_en, bus.pack_lane);
    end
    rst = 1'b0; #1;
    checks++;
    if ({bus.hold_get_next_data, bus.s_wready, bus.pack_en, bus.pack_lane, bus.pack_clr,
         bus.m_wvalid, bus.m_wlast, bus.err_early_last} !== 13'h0) begin
      errors++; $display("FAIL rstmid_outputs got nonzero outputs exp all 0");
    end
    bus.s_wvalid = 1'b0; bus.hold_reg_empty = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    run_entry(6'h00, 6'd4, 8'd1, 1'b0, 1'b0, 4, 3, 0, 1'b0);
    checks++; if (lane_hist !== 64'h0004_0004 || mlast_hist !== 8'b01 || hold_cnt != 1) begin errors++; $display("FAIL rstmid_restart got %h/%b/%0d exp 00040004/01/1", lane_hist, mlast_hist, hold_cnt); end
  endtask

  initial begin
    bus.hold_reg_empty = 1'b1; bus.addr = 6'h00; bus.size_shifted = 6'd4; bus.mask_addr = 6'h07;
    bus.wlen_mst = 8'd0; bus.fixed_flag = 1'b0; bus.extend_tx = 1'b0;
    bus.s_wvalid = 1'b0; bus.s_wlast = 1'b0; bus.m_wready = 1'b0;
    test_reset();
    test_incr();
    test_unaligned();
    test_fixed();
    test_byte();
    test_backpressure();
    test_early_last();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
